// File: rtl/seqrep_monitor.sv
// Checker/scheduler for a bounded consecutive-repetition sequence expr[*lo:hi].
// Tracks overlapping attempts in a one-hot-per-length alive vector and reports events and statistics.
module seqrep_monitor #(
    parameter int HMAX = 8,
    parameter int CW   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        go,
    input  logic                        stop,
    input  logic [$clog2(HMAX+1)-1:0]   cfg_lo,
    input  logic [$clog2(HMAX+1)-1:0]   cfg_hi,
    input  logic                        start,
    input  logic                        expr,
    output logic                        busy,
    output logic                        cfg_err,
    output logic                        pass_o,
    output logic                        fail_o,
    output logic                        match_o,
    output logic                        done_o,
    output logic [CW-1:0]               att_cnt,
    output logic [CW-1:0]               pass_cnt,
    output logic [CW-1:0]               fail_cnt,
    output logic [CW-1:0]               match_cnt
);

    localparam int LW = $clog2(HMAX + 1);
    localparam int NW = $clog2(HMAX + 2);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state;
    logic [LW-1:0]     lo;
    logic [LW-1:0]     hi;
    logic [HMAX-1:0]   v;
    logic [HMAX-1:0]   v_next;
    logic              s;
    logic              cfg_ok;
    logic              pass_n;
    logic [NW-1:0]     fail_num;
    logic [NW-1:0]     match_num;

    assign s      = start && (state == RUN);
    assign cfg_ok = (cfg_lo != '0) && (cfg_lo <= cfg_hi) && (cfg_hi <= LW'(HMAX));

    // Widened sum so a multi-attempt increment can never wrap past all-ones.
    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [NW-1:0] b);
        logic [CW+NW-1:0] sum;
        sum = (CW+NW)'(a) + (CW+NW)'(b);
        if (sum > (CW+NW)'({CW{1'b1}}))
            return {CW{1'b1}};
        return sum[CW-1:0];
    endfunction

    always_comb begin
        v_next    = '0;
        pass_n    = 1'b0;
        fail_num  = '0;
        match_num = '0;
        v_next[0] = s & expr;
        for (int k = 1; k < HMAX; k++) begin
            if (k < int'(hi))
                v_next[k] = v[k-1] & expr;
        end
        if (s && !expr)
            fail_num = NW'(1);
        // Lengths are k+1: fails die short of lo, a pass is the new length-lo entry.
        for (int k = 0; k < HMAX; k++) begin
            if (!expr && v[k] && (k + 1 < int'(lo)))
                fail_num = fail_num + NW'(1);
            if (v_next[k] && (k + 1 >= int'(lo)) && (k + 1 <= int'(hi)))
                match_num = match_num + NW'(1);
            if (v_next[k] && (k + 1 == int'(lo)))
                pass_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lo        <= LW'(1);
            hi        <= LW'(1);
            v         <= '0;
            busy      <= 1'b0;
            cfg_err   <= 1'b0;
            pass_o    <= 1'b0;
            fail_o    <= 1'b0;
            match_o   <= 1'b0;
            done_o    <= 1'b0;
            att_cnt   <= '0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            match_cnt <= '0;
        end else begin
            v         <= v_next;
            pass_o    <= pass_n;
            fail_o    <= (fail_num != '0);
            match_o   <= (match_num != '0);
            done_o    <= 1'b0;
            att_cnt   <= sat_add(att_cnt, NW'(s));
            pass_cnt  <= sat_add(pass_cnt, NW'(pass_n));
            fail_cnt  <= sat_add(fail_cnt, fail_num);
            match_cnt <= sat_add(match_cnt, match_num);
            case (state)
                IDLE: begin
                    if (go) begin
                        if (cfg_ok) begin
                            lo        <= cfg_lo;
                            hi        <= cfg_hi;
                            cfg_err   <= 1'b0;
                            state     <= RUN;
                            busy      <= 1'b1;
                            att_cnt   <= '0;
                            pass_cnt  <= '0;
                            fail_cnt  <= '0;
                            match_cnt <= '0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (stop)
                        state <= DRAIN;
                end
                DRAIN: begin
                    // Attempts keep evaluating here; leave only once nothing is alive.
                    if (v == '0) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seqrep_monitor.sv
// Directed, table-driven bench for seqrep_monitor plus hand sequences for saturation and async reset.
module tb_seqrep_monitor;

    localparam int HMAX = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        go, stop, start, expr;
    logic [3:0]  cfg_lo, cfg_hi;
    logic        busy, cfg_err, pass_o, fail_o, match_o, done_o;
    logic [15:0] att_cnt, pass_cnt, fail_cnt, match_cnt;
    logic        busy4, cfg_err4, pass4, fail4, match4, done4;
    logic [3:0]  att4, passc4, failc4, matchc4;

    always #5 clk = ~clk;

    seqrep_monitor #(.HMAX(HMAX), .CW(16)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .stop(stop), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
        .start(start), .expr(expr), .busy(busy), .cfg_err(cfg_err), .pass_o(pass_o),
        .fail_o(fail_o), .match_o(match_o), .done_o(done_o), .att_cnt(att_cnt),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .match_cnt(match_cnt)
    );

    seqrep_monitor #(.HMAX(HMAX), .CW(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .go(go), .stop(stop), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
        .start(start), .expr(expr), .busy(busy4), .cfg_err(cfg_err4), .pass_o(pass4),
        .fail_o(fail4), .match_o(match4), .done_o(done4), .att_cnt(att4),
        .pass_cnt(passc4), .fail_cnt(failc4), .match_cnt(matchc4)
    );

    typedef struct packed {
        logic        busy, cfg_err, pass_o, fail_o, match_o, done_o;
        logic [15:0] att, pc, fc, mc;
    } out_t;

    typedef struct {
        logic       go, stop;
        logic [3:0] lo, hi;
        logic       start, expr;
        out_t       exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input int g, input int st, input int lo, input int hi, input int sa, input int ex,
                       input int b, input int ce, input int p, input int f, input int m, input int d,
                       input int a, input int pc, input int fc, input int mc);
        vec_t t;
        t.go = g[0]; t.stop = st[0]; t.lo = 4'(lo); t.hi = 4'(hi); t.start = sa[0]; t.expr = ex[0];
        t.exp = {b[0], ce[0], p[0], f[0], m[0], d[0], 16'(a), 16'(pc), 16'(fc), 16'(mc)};
        vecs.push_back(t);
    endtask

    task automatic apply_stimulus(input logic g, input logic st, input logic [3:0] lo,
                                  input logic [3:0] hi, input logic sa, input logic ex);
        go = g; stop = st; cfg_lo = lo; cfg_hi = hi; start = sa; expr = ex;
    endtask

    task automatic check_output(input string name, input out_t exp);
        out_t act;
        act = {busy, cfg_err, pass_o, fail_o, match_o, done_o, att_cnt, pass_cnt, fail_cnt, match_cnt};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got busy=%b err=%b pass=%b fail=%b match=%b done=%b cnt=%0d/%0d/%0d/%0d, expected busy=%b err=%b pass=%b fail=%b match=%b done=%b cnt=%0d/%0d/%0d/%0d",
                     name, act.busy, act.cfg_err, act.pass_o, act.fail_o, act.match_o, act.done_o,
                     act.att, act.pc, act.fc, act.mc, exp.busy, exp.cfg_err, exp.pass_o, exp.fail_o,
                     exp.match_o, exp.done_o, exp.att, exp.pc, exp.fc, exp.mc);
        end
    endtask

    task automatic check_value(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic g, input logic st, input logic [3:0] lo, input logic [3:0] hi,
                        input logic sa, input logic ex);
        apply_stimulus(g, st, lo, hi, sa, ex);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //   go st lo hi sa ex | busy err p f m d | att pc fc mc
        // lo=3, hi=4: one attempt, five trues
        add(1,0,3,4,0,0, 1,0,0,0,0,0, 0,0,0,0);
        add(0,0,3,4,1,1, 1,0,0,0,0,0, 1,0,0,0);
        add(0,0,3,4,0,1, 1,0,0,0,0,0, 1,0,0,0);
        add(0,0,3,4,0,1, 1,0,1,0,1,0, 1,1,0,1);
        add(0,0,3,4,0,1, 1,0,0,0,1,0, 1,1,0,2);
        add(0,0,3,4,0,1, 1,0,0,0,0,0, 1,1,0,2);
        add(0,1,3,4,0,0, 1,0,0,0,0,0, 1,1,0,2);
        add(0,0,3,4,0,0, 0,0,0,0,0,1, 1,1,0,2);
        add(0,0,3,4,0,0, 0,0,0,0,0,0, 1,1,0,2);
        // overlapping attempts, stop with attempts alive, drain
        add(1,0,3,4,0,0, 1,0,0,0,0,0, 0,0,0,0);
        add(0,0,3,4,1,1, 1,0,0,0,0,0, 1,0,0,0);
        add(0,0,3,4,1,1, 1,0,0,0,0,0, 2,0,0,0);
        add(0,0,3,4,1,1, 1,0,1,0,1,0, 3,1,0,1);
        add(0,0,3,4,1,1, 1,0,1,0,1,0, 4,2,0,3);
        add(0,0,3,4,1,1, 1,0,1,0,1,0, 5,3,0,5);
        add(0,0,3,4,1,1, 1,0,1,0,1,0, 6,4,0,7);
        add(0,1,3,4,0,1, 1,0,1,0,1,0, 6,5,0,9);
        add(0,0,3,4,1,1, 1,0,1,0,1,0, 6,6,0,11);
        add(0,0,3,4,1,1, 1,0,0,0,1,0, 6,6,0,12);
        add(0,0,3,4,0,1, 1,0,0,0,0,0, 6,6,0,12);
        add(0,0,3,4,0,1, 0,0,0,0,0,1, 6,6,0,12);
        // early failures, start honoured on the stop sample
        add(1,0,3,4,0,0, 1,0,0,0,0,0, 0,0,0,0);
        add(0,0,3,4,1,1, 1,0,0,0,0,0, 1,0,0,0);
        add(0,0,3,4,0,1, 1,0,0,0,0,0, 1,0,0,0);
        add(0,0,3,4,0,0, 1,0,0,1,0,0, 1,0,1,0);
        add(0,0,3,4,1,0, 1,0,0,1,0,0, 2,0,2,0);
        add(0,0,3,4,0,0, 1,0,0,0,0,0, 2,0,2,0);
        add(0,0,3,4,1,1, 1,0,0,0,0,0, 3,0,2,0);
        add(0,0,3,4,1,1, 1,0,0,0,0,0, 4,0,2,0);
        add(0,0,3,4,1,1, 1,0,1,0,1,0, 5,1,2,1);
        add(0,1,3,4,1,0, 1,0,0,1,0,0, 6,1,5,1);
        add(0,0,3,4,0,0, 0,0,0,0,0,1, 6,1,5,1);
        add(0,0,3,4,0,0, 0,0,0,0,0,0, 6,1,5,1);
        // illegal configurations, then legal hi=HMAX; go ignored in RUN
        add(1,0,5,4,0,0, 0,1,0,0,0,0, 6,1,5,1);
        add(0,0,5,4,1,1, 0,1,0,0,0,0, 6,1,5,1);
        add(1,0,0,4,0,0, 0,1,0,0,0,0, 6,1,5,1);
        add(1,0,1,9,0,0, 0,1,0,0,0,0, 6,1,5,1);
        add(1,0,1,8,0,0, 1,0,0,0,0,0, 0,0,0,0);
        add(0,0,1,8,1,1, 1,0,1,0,1,0, 1,1,0,1);
        add(1,0,5,4,0,1, 1,0,0,0,1,0, 1,1,0,2);
        add(0,1,1,8,0,0, 1,0,0,0,0,0, 1,1,0,2);
        add(0,0,1,8,0,0, 0,0,0,0,0,1, 1,1,0,2);

        apply_stimulus(0, 0, 4'd0, 4'd0, 0, 0);
        rst_n = 1'b0;
        #12;
        check_output("reset", '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].go, vecs[i].stop, vecs[i].lo, vecs[i].hi, vecs[i].start, vecs[i].expr);
            @(posedge clk);
            #1;
            check_output($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Saturation with lo=hi=1: every start is both a pass and a match
        step(1, 0, 4'd1, 4'd1, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            step(0, 0, 4'd1, 4'd1, 1, 1);
            if (i == 15)
                check_value("sat4_att_at15", int'(att4), 15);
        end
        check_value("sat4_att", int'(att4), 15);
        check_value("sat4_pass", int'(passc4), 15);
        check_value("sat4_match", int'(matchc4), 15);
        check_value("sat4_fail", int'(failc4), 0);
        check_value("sat16_att", int'(att_cnt), 20);
        check_value("sat16_pass", int'(pass_cnt), 20);
        step(0, 1, 4'd1, 4'd1, 0, 0);
        step(0, 0, 4'd1, 4'd1, 0, 0);
        check_value("sat_done", int'(done_o), 1);

        // Async reset with three attempts alive
        step(1, 0, 4'd3, 4'd4, 0, 0);
        step(0, 0, 4'd3, 4'd4, 1, 1);
        step(0, 0, 4'd3, 4'd4, 1, 1);
        step(0, 0, 4'd3, 4'd4, 1, 1);
        check_output("pre_reset", {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd3, 16'd1, 16'd0, 16'd1});
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_reset", '0);
        check_value("async_reset_cnt4", int'(att4), 0);
        #2;
        rst_n = 1'b1;
        step(0, 0, 4'd3, 4'd4, 1, 1);
        step(0, 0, 4'd3, 4'd4, 1, 1);
        check_output("post_reset_idle", '0);
        step(1, 0, 4'd3, 4'd4, 0, 0);
        check_output("post_reset_go", {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seqrep_monitor.md
# seqrep_monitor

Hardware checker and scheduler for a bounded consecutive-repetition sequence `expr[*lo:hi]`, sampled on the rising edge of `clk`. Launches one attempt on each sampled `start`, tracks every overlapping attempt in flight, and reports per-cycle pass, fail and match events plus saturating statistics. Sits beside the assertion/monitor datapath. A small run-control FSM arms it with runtime bounds, then stops launching and drains outstanding attempts.

## Interface
- `HMAX`, default 8: maximum supported `hi`. Also the depth of the attempt-tracking vector. Legal range 1..32.
- `CW`, default 16: width of the statistics counters.
- `clk` in 1: sampling clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `go` in 1: arm request, honoured only in IDLE. Latches `cfg_lo` and `cfg_hi`.
- `stop` in 1: stop launching new attempts. Honoured only in RUN.
- `cfg_lo` in $clog2(HMAX+1): minimum repetition count.
- `cfg_hi` in $clog2(HMAX+1): maximum repetition count.
- `start` in 1: launch an attempt this sample. Honoured only in RUN.
- `expr` in 1: the boolean being repeated.
- `busy` out 1: high in RUN or DRAIN.
- `cfg_err` out 1: sticky flag. Set by an illegal `go`. Cleared by the next legal `go`.
- `pass_o` out 1: some attempt reached exactly `lo` consecutive trues.
- `fail_o` out 1: some attempt died with fewer than `lo` trues.
- `match_o` out 1: some attempt's current length is in [`lo`,`hi`].
- `done_o` out 1: one-cycle pulse on the DRAIN→IDLE transition.
- `att_cnt`, `pass_cnt`, `fail_cnt`, `match_cnt` out CW: saturating statistics. All are cleared by a legal `go`.

## Operation
- **Configuration is legal** when 1 ≤ `cfg_lo` ≤ `cfg_hi` ≤ HMAX. The latched values are `lo` and `hi`.
- **FSM states:** IDLE, RUN, DRAIN.
  - IDLE→RUN on a legal `go`. A `go` with illegal bounds sets `cfg_err` and stays in IDLE.
  - RUN→DRAIN on `stop`.
  - DRAIN→IDLE when the alive vector `v` is all zero.
  - `go` is ignored outside IDLE. `stop` is ignored outside RUN.
- **Alive vector:** `v[0..HMAX-1]`. `v[k]=1` means an attempt has seen exactly k+1 consecutive trues, ending at the latest sample.
- **Vector update per edge.** Let `s = start && state==RUN`.
  - `v[0] ← s & expr`.
  - `v[k] ← v[k-1] & expr` for 1 ≤ k < `hi`.
  - `v[k] ← 0` for k ≥ `hi`. An attempt retires after length `hi`.
- **Events,** computed from the same sample and registered with `v`:
  - pass when `s&expr` and `lo`=1, or when `v_prev[lo-2]&expr`.
  - fail when `s&!expr`, or when `!expr` and any `v_prev[k]` with k+1 < `lo`.
  - match when any new `v[k]` has `lo` ≤ k+1 ≤ `hi`.
- **Counter increments:**
  - `att_cnt` += `s`.
  - `pass_cnt` += the number of attempts passing. This is at most 1, since a given length has only one attempt.
  - `fail_cnt` += the popcount of dying attempts that are below `lo`.
  - `match_cnt` += the popcount of new `v[lo-1..hi-1]`.
  - All counters saturate at 2^CW−1. Use width-safe addition: do not wrap.
- **Attempt outcomes:** an attempt that dies on `!expr` after reaching `lo` is neither a fail nor a new pass. In DRAIN, in-flight attempts continue to evaluate normally.

## Timing
- **Reset values:** state IDLE, `v`=0, `lo`=`hi`=1, and every output 0.
- **Latency:** for an event sampled at edge t, `pass_o`/`fail_o`/`match_o` and the counters are valid in the cycle after edge t. Event outputs are single-cycle unless re-triggered.
- `busy` rises in the cycle after the edge that accepted `go`.
- In the sample where `stop` is seen in RUN, `start` is still honoured; the transition occurs on that edge.
- If `v` is already zero on entry to DRAIN, DRAIN lasts exactly one cycle and `done_o` pulses at its end.
- **Asynchronous reset mid-operation:** clears `v`, the FSM, the counters and `cfg_err` immediately. No `done_o` pulse is produced.
- **Simultaneous events:** `pass_o`, `fail_o` and `match_o` may all be high in the same cycle, from different attempts.

## Test plan
- **Basic 3..4 match:** `go` with lo=3, hi=4; `start` at one sample, then `expr`=1 for 5 samples → `pass_o` once, 3rd sample; `match_o` on the 3rd and 4th samples; `match_cnt`=2; `fail_cnt`=0.
- **Overlapping attempts:** lo=3, hi=4; `start`=`expr`=1 for 6 samples, then `stop` → `att_cnt`=6; `pass_cnt`=4; after drain, `done_o` pulses once and `busy`=0.
- **Early failure:** lo=3, hi=4; `start` with `expr` 1,1,0 → `fail_o` on the 3rd sample; `fail_cnt`=1; an attempt launched with `expr`=0 fails immediately.
- **Illegal configuration:** `go` with lo=5, hi=4, or lo=0, or hi=HMAX+1 → `cfg_err`=1, state stays IDLE, `start` is ignored. A following legal `go` clears `cfg_err`.
- **Saturation:** CW=4, lo=hi=1; 20 starts with `expr`=1 → `att_cnt`=`pass_cnt`=`match_cnt`=15.
- **Reset mid-run:** assert `rst_n`=0 asynchronously with 3 attempts alive → all outputs 0 at once. After release, `busy`=0 until a new `go`.
